// File: rtl/ext_bus_sequencer_if.sv
// Requester, read-data and pad-side signals of the external bus sequencer.
// master = requesters plus pad model, slave = the sequencer itself.
interface ext_bus_sequencer_if;
    logic        req0;
    logic        we0;
    logic [15:0] addr0;
    logic [7:0]  wdata0;
    logic        ack0;
    logic        req1;
    logic        we1;
    logic [15:0] addr1;
    logic [7:0]  wdata1;
    logic        ack1;
    logic [7:0]  rdata;
    logic [7:0]  bus_i;
    logic [7:0]  bus_o;
    logic        bus_oe;
    logic        le_hi;
    logic        le_lo;
    logic        oe_n;
    logic        we_n;
    logic        busy;

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output bus_i,
        input  ack0, ack1, rdata,
        input  bus_o, bus_oe, le_hi, le_lo,
        input  oe_n, we_n, busy
    );

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  bus_i,
        output ack0, ack1, rdata,
        output bus_o, bus_oe, le_hi, le_lo,
        output oe_n, we_n, busy
    );
endinterface

// File: rtl/ext_bus_sequencer.sv
// Two-port round-robin sequencer for the multiplexed 8-bit external bus.
// Optional HI_ADDR_SKIP_EN skips the high-address phase on a repeated page.
module ext_bus_sequencer #(
    parameter int unsigned WAIT_STATES = 0
) (
    input logic                wb_clk_i,
    input logic                wb_rst_i,
    ext_bus_sequencer_if.slave sif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_HI_HOLD,
        S_LO,
        S_LO_HOLD,
        S_DATA,
        S_TURN
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        gnt_q;
    logic        we_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic        last_grant_q;

    logic        le_hi_q, le_lo_q, oe_n_q, we_n_q;
    logic        bus_oe_q, ack0_q, ack1_q, busy_q;
    logic [7:0]  bus_o_q, rdata_q;

    logic        le_hi_d, le_lo_d, oe_n_d, we_n_d;
    logic        bus_oe_d, ack0_d, ack1_d;
    logic [7:0]  bus_o_d;

    logic        req_any;
    logic        win;
    logic        cur_port;
    logic        cur_we;
    logic [15:0] cur_addr;
    logic [7:0]  cur_wdata;
    logic        skip;

`ifdef HI_ADDR_SKIP_EN
    logic [7:0]  last_hi_q;
    logic        hi_valid_q;

    assign skip = hi_valid_q && (cur_addr[15:8] == last_hi_q);
`else
    assign skip = 1'b0;
`endif

    assign req_any = sif.req0 | sif.req1;

    always_comb begin
        win = 1'b0;
        unique case (1'b1)
            (sif.req0 && sif.req1):  win = ~last_grant_q;
            (sif.req1 && !sif.req0): win = 1'b1;
            default:                 win = 1'b0;
        endcase
    end

    // In IDLE the outputs for HI/LO are built from the live winner inputs
    always_comb begin
        cur_port  = gnt_q;
        cur_we    = we_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        if (state_q == S_IDLE) begin
            cur_port  = win;
            cur_we    = win ? sif.we1 : sif.we0;
            cur_addr  = win ? sif.addr1 : sif.addr0;
            cur_wdata = win ? sif.wdata1 : sif.wdata0;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = 3'd0;
        le_hi_d  = 1'b0;
        le_lo_d  = 1'b0;
        oe_n_d   = 1'b1;
        we_n_d   = 1'b1;
        bus_oe_d = 1'b0;
        bus_o_d  = 8'h00;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (req_any)
                    state_d = skip ? S_LO : S_HI;
            end
            S_HI:      state_d = S_HI_HOLD;
            S_HI_HOLD: state_d = S_LO;
            S_LO:      state_d = S_LO_HOLD;
            S_LO_HOLD: state_d = S_DATA;
            S_DATA: begin
                if (cnt_q == 3'(WAIT_STATES))
                    state_d = S_TURN;
                else
                    cnt_d = cnt_q + 3'd1;
            end
            S_TURN:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        // Outputs are registered, so decode them from the next state
        unique case (state_d)
            S_HI, S_HI_HOLD: begin
                le_hi_d  = (state_d == S_HI);
                bus_oe_d = 1'b1;
                bus_o_d  = cur_addr[15:8];
            end
            S_LO, S_LO_HOLD: begin
                le_lo_d  = (state_d == S_LO);
                bus_oe_d = 1'b1;
                bus_o_d  = cur_addr[7:0];
            end
            S_DATA: begin
                if (cur_we) begin
                    we_n_d   = 1'b0;
                    bus_oe_d = 1'b1;
                    bus_o_d  = cur_wdata;
                end else begin
                    oe_n_d = 1'b0;
                end
            end
            S_TURN: begin
                ack0_d = ~cur_port;
                ack1_d = cur_port;
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= 3'd0;
            gnt_q        <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= 16'h0000;
            wdata_q      <= 8'h00;
            last_grant_q <= 1'b1;
            le_hi_q      <= 1'b0;
            le_lo_q      <= 1'b0;
            oe_n_q       <= 1'b1;
            we_n_q       <= 1'b1;
            bus_oe_q     <= 1'b0;
            bus_o_q      <= 8'h00;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata_q      <= 8'h00;
            busy_q       <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            le_hi_q  <= le_hi_d;
            le_lo_q  <= le_lo_d;
            oe_n_q   <= oe_n_d;
            we_n_q   <= we_n_d;
            bus_oe_q <= bus_oe_d;
            bus_o_q  <= bus_o_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            busy_q   <= (state_d != S_IDLE);
            if (state_q == S_IDLE && req_any) begin
                gnt_q        <= win;
                last_grant_q <= win;
                we_q         <= cur_we;
                addr_q       <= cur_addr;
                wdata_q      <= cur_wdata;
            end
            if (state_q == S_DATA && state_d == S_TURN && !we_q)
                rdata_q <= sif.bus_i;
        end
    end

`ifdef HI_ADDR_SKIP_EN
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            last_hi_q  <= 8'h00;
            hi_valid_q <= 1'b0;
        end else if (state_d == S_HI) begin
            last_hi_q  <= cur_addr[15:8];
            hi_valid_q <= 1'b1;
        end
    end
`endif

    assign sif.le_hi  = le_hi_q;
    assign sif.le_lo  = le_lo_q;
    assign sif.oe_n   = oe_n_q;
    assign sif.we_n   = we_n_q;
    assign sif.bus_oe = bus_oe_q;
    assign sif.bus_o  = bus_o_q;
    assign sif.ack0   = ack0_q;
    assign sif.ack1   = ack1_q;
    assign sif.rdata  = rdata_q;
    assign sif.busy   = busy_q;

endmodule

// File: tb/tb_ext_bus_sequencer.sv
// Directed bench for ext_bus_sequencer: zero and three wait-state instances.
// Page-skip expectations switch on HI_ADDR_SKIP_EN.
module tb_ext_bus_sequencer;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    ext_bus_sequencer_if if0 ();
    ext_bus_sequencer_if if3 ();

    ext_bus_sequencer #(.WAIT_STATES(0)) u0 (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .sif     (if0.slave)
    );

    ext_bus_sequencer #(.WAIT_STATES(3)) u3 (
        .wb_clk_i(clk),
        .wb_rst_i(rst),
        .sif     (if3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe and ack exclusivity on both instances, every cycle after reset
    always @(negedge clk) begin
        if (!rst) begin
            chk("excl0", {13'd0, if0.ack0 & if0.ack1,
                          ~if0.oe_n & ~if0.we_n, if0.le_hi & if0.le_lo}, 16'd0);
            chk("excl3", {13'd0, if3.ack0 & if3.ack1,
                          ~if3.oe_n & ~if3.we_n, if3.le_hi & if3.le_lo}, 16'd0);
        end
    end

    task automatic do_read0(input logic [15:0] a, input logic [7:0] d,
                            input bit skip, input string t);
        if0.req0  = 1'b1;
        if0.we0   = 1'b0;
        if0.addr0 = a;
        tick();
        if (!skip) begin
            chk({t, ".le_hi"}, 16'(if0.le_hi), 16'd1);
            chk({t, ".hi"}, 16'(if0.bus_o), 16'(a[15:8]));
            tick();
            tick();
        end else begin
            chk({t, ".no_hi"}, 16'(if0.le_hi), 16'd0);
        end
        chk({t, ".le_lo"}, 16'(if0.le_lo), 16'd1);
        chk({t, ".lo"}, 16'(if0.bus_o), 16'(a[7:0]));
        tick();
        tick();
        chk({t, ".oe"}, 16'(if0.oe_n), 16'd0);
        if0.bus_i = d;
        tick();
        chk({t, ".ack"}, 16'(if0.ack0), 16'd1);
        chk({t, ".rdata"}, 16'(if0.rdata), 16'(d));
        if0.req0 = 1'b0;
        tick();
        chk({t, ".idle"}, 16'(if0.busy), 16'd0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        {if0.req0, if0.we0, if0.addr0, if0.wdata0} = '0;
        {if0.req1, if0.we1, if0.addr1, if0.wdata1} = '0;
        if0.bus_i = 8'h00;
        {if3.req0, if3.we0, if3.addr0, if3.wdata0} = '0;
        {if3.req1, if3.we1, if3.addr1, if3.wdata1} = '0;
        if3.bus_i = 8'h00;
        tick();
        tick();

        // Reset values
        chk("rst.busy", 16'(if0.busy), 16'd0);
        chk("rst.oe_n", 16'(if0.oe_n), 16'd1);
        chk("rst.we_n", 16'(if0.we_n), 16'd1);
        chk("rst.bus", {7'd0, if0.bus_oe, if0.bus_o}, 16'd0);
        chk("rst.le", {14'd0, if0.le_hi, if0.le_lo}, 16'd0);
        chk("rst.ack", {14'd0, if0.ack0, if0.ack1}, 16'd0);
        chk("rst.rdata", 16'(if0.rdata), 16'd0);
        rst = 1'b0;
        tick();

        // 1: port 0 read of 0x1234
        if0.req0  = 1'b1;
        if0.we0   = 1'b0;
        if0.addr0 = 16'h1234;
        tick();
        chk("t1.le_hi", 16'(if0.le_hi), 16'd1);
        chk("t1.hi", {7'd0, if0.bus_oe, if0.bus_o}, 16'h112);
        chk("t1.busy", 16'(if0.busy), 16'd1);
        tick();
        chk("t1.hold", {6'd0, if0.le_hi, if0.bus_oe, if0.bus_o}, 16'h112);
        tick();
        chk("t1.le_lo", 16'(if0.le_lo), 16'd1);
        chk("t1.lo", 16'(if0.bus_o), 16'h34);
        tick();
        chk("t1.lo_hold", {7'd0, if0.le_lo, if0.bus_o}, 16'h034);
        tick();
        chk("t1.oe", {14'd0, if0.oe_n, if0.bus_oe}, 16'd0);
        chk("t1.noack", 16'(if0.ack0), 16'd0);
        if0.bus_i = 8'hA5;
        tick();
        chk("t1.ack", 16'(if0.ack0), 16'd1);
        chk("t1.rdata", 16'(if0.rdata), 16'hA5);
        chk("t1.oe_off", 16'(if0.oe_n), 16'd1);
        if0.req0  = 1'b0;
        if0.bus_i = 8'h00;
        tick();
        chk("t1.ack_end", 16'(if0.ack0), 16'd0);
        chk("t1.idle", 16'(if0.busy), 16'd0);
        tick();
        chk("t1.once", 16'(if0.busy), 16'd0);

        // 2: port 1 write 0x5A to 0x00C8
        if0.req1   = 1'b1;
        if0.we1    = 1'b1;
        if0.addr1  = 16'h00C8;
        if0.wdata1 = 8'h5A;
        tick();
        chk("t2.hi", {6'd0, if0.le_hi, if0.bus_oe, if0.bus_o}, 16'h300);
        tick();
        tick();
        chk("t2.lo", {7'd0, if0.le_lo, if0.bus_o}, 16'h1C8);
        tick();
        tick();
        chk("t2.we", {13'd0, if0.we_n, if0.oe_n, if0.bus_oe}, 16'b011);
        chk("t2.wdata", 16'(if0.bus_o), 16'h5A);
        tick();
        chk("t2.ack", {14'd0, if0.ack1, if0.ack0}, 16'b10);
        chk("t2.we_off", 16'(if0.we_n), 16'd1);
        if0.req1 = 1'b0;
        tick();
        chk("t2.ack_end", {14'd0, if0.ack1, if0.ack0}, 16'd0);
        chk("t2.rdata_kept", 16'(if0.rdata), 16'hA5);

        // 3: both ports held for four accesses, grants alternate
        if0.req0  = 1'b1;
        if0.we0   = 1'b0;
        if0.addr0 = 16'h2000;
        if0.req1  = 1'b1;
        if0.we1   = 1'b0;
        if0.addr1 = 16'h3000;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("t3.%0d.hi", k), {7'd0, if0.le_hi, if0.bus_o},
                (k % 2 == 0) ? 16'h120 : 16'h130);
            for (int c = 1; c < 5; c++) begin
                tick();
                chk($sformatf("t3.%0d.noack%0d", k, c),
                    {14'd0, if0.ack1, if0.ack0}, 16'd0);
            end
            tick();
            chk($sformatf("t3.%0d.ack", k), {14'd0, if0.ack1, if0.ack0},
                (k % 2 == 0) ? 16'b01 : 16'b10);
            if (k == 3) begin
                if0.req0 = 1'b0;
                if0.req1 = 1'b0;
            end
            tick();
            chk($sformatf("t3.%0d.idle", k), 16'(if0.busy), 16'd0);
        end

        // 4: three wait states, read
        if3.req0  = 1'b1;
        if3.we0   = 1'b0;
        if3.addr0 = 16'h4321;
        tick();
        chk("t4.hi", {7'd0, if3.le_hi, if3.bus_o}, 16'h143);
        tick();
        tick();
        tick();
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("t4.oe%0d", c), 16'(if3.oe_n), 16'd0);
            if3.bus_i = (c == 3) ? 8'hC3 : 8'(c + 1);
        end
        tick();
        chk("t4.oe_off", 16'(if3.oe_n), 16'd1);
        chk("t4.ack", 16'(if3.ack0), 16'd1);
        chk("t4.rdata", 16'(if3.rdata), 16'hC3);
        if3.req0 = 1'b0;
        tick();
        chk("t4.idle", 16'(if3.busy), 16'd0);

        // 5: reset during a write DATA phase
        if0.req0   = 1'b1;
        if0.we0    = 1'b1;
        if0.addr0  = 16'h5555;
        if0.wdata0 = 8'h77;
        for (int c = 0; c < 5; c++) tick();
        chk("t5.we", 16'(if0.we_n), 16'd0);
        rst      = 1'b1;
        if0.req0 = 1'b0;
        tick();
        chk("t5.we_off", 16'(if0.we_n), 16'd1);
        chk("t5.bus", {7'd0, if0.bus_oe, if0.bus_o}, 16'd0);
        chk("t5.busy", 16'(if0.busy), 16'd0);
        chk("t5.ack", {14'd0, if0.ack1, if0.ack0}, 16'd0);
        rst = 1'b0;
        tick();
        chk("t5.no_late_ack", {14'd0, if0.ack1, if0.ack0}, 16'd0);
        do_read0(16'h6789, 8'h3C, 1'b0, "t5.rd");

        // 6: repeated high byte
        do_read0(16'h1200, 8'h11, 1'b0, "t6.a");
`ifdef HI_ADDR_SKIP_EN
        do_read0(16'h12FF, 8'h99, 1'b1, "t6.b");
`else
        do_read0(16'h12FF, 8'h99, 1'b0, "t6.b");
`endif
        do_read0(16'h1300, 8'h5E, 1'b0, "t6.c");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
